// File: rtl/video_pix_shift_if.sv
// Bus between the fetch stage, pixel serializer and palette mux.
// The serializer uses the slave modport; the driving side uses master.
interface video_pix_shift_if;
   logic [1:0]  mode;
   logic [3:0]  palsel;
   logic        fetch_stb;
   logic [31:0] fetch_data;
   logic        pix_stb;
   logic        line_start;
   logic        flash_ph;
   logic [7:0]  pix_index;
   logic        pix_valid;
   logic        underrun;
   logic        overrun;

   modport master (
      output mode, palsel, fetch_stb, fetch_data, pix_stb, line_start, flash_ph,
      input  pix_index, pix_valid, underrun, overrun
   );

   modport slave (
      input  mode, palsel, fetch_stb, fetch_data, pix_stb, line_start, flash_ph,
      output pix_index, pix_valid, underrun, overrun
   );
endinterface

// File: rtl/video_pix_shift.sv
// Pixel serializer: one-word hold buffer feeding a shifter that emits 4bpp/8bpp/ZX palette indices.
// Optional ZX flash (ink/paper swap on attr[7] & flash_ph) enabled by defining VIDEO_SHIFT_FLASH_EN.
module video_pix_shift (
   input  logic               clk,
   input  logic               rst,
   video_pix_shift_if.slave   vif
);

   localparam logic [1:0] MODE_4BPP = 2'd0;
   localparam logic [1:0] MODE_8BPP = 2'd1;
   localparam logic [1:0] MODE_ZX   = 2'd2;

   logic [31:0] hold_data_reg, hold_data_next;
   logic        hold_full_reg, hold_full_next;
   logic [31:0] sh_data_reg, sh_data_next;
   logic [1:0]  sh_mode_reg, sh_mode_next;
   logic [4:0]  sh_cnt_reg, sh_cnt_next;
   logic [7:0]  pix_index_reg, pix_index_next;
   logic        pix_valid_reg, pix_valid_next;
   logic        underrun_reg, underrun_next;
   logic        overrun_reg, overrun_next;

   logic        sh_empty;
   logic        load;
   logic [31:0] src_data;
   logic [1:0]  src_mode;
   logic [3:0]  src_idx;
   logic [7:0]  pix_sel;
   logic        flash_on;

   logic [3:0]  nib_tab  [8];
   logic [7:0]  byte_tab [4];
   logic [7:0]  zx_tab   [16];

   function automatic logic [4:0] pix_per_word(input logic [1:0] m);
      case (m)
         MODE_4BPP: pix_per_word = 5'd8;
         MODE_8BPP: pix_per_word = 5'd4;
         MODE_ZX:   pix_per_word = 5'd16;
         default:   pix_per_word = 5'd0;
      endcase
   endfunction

`ifdef VIDEO_SHIFT_FLASH_EN
   assign flash_on = vif.flash_ph;
`else
   logic unused_flash_ph;
   assign unused_flash_ph = vif.flash_ph;
   assign flash_on        = 1'b0;
`endif

   // The pixel source is the hold word on a load cycle, otherwise the word in flight.
   assign sh_empty = (sh_cnt_reg == 5'd0);
   assign load     = vif.pix_stb && sh_empty && hold_full_reg && (vif.mode != 2'd3);
   assign src_data = load ? hold_data_reg : sh_data_reg;
   assign src_mode = load ? vif.mode : sh_mode_reg;
   assign src_idx  = load ? 4'd0 : 4'(pix_per_word(sh_mode_reg) - sh_cnt_reg);

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_nib
         // Even pixels take the high nibble of their byte.
         assign nib_tab[gi] = src_data[(gi / 2) * 8 + ((gi % 2 == 0) ? 4 : 0) +: 4];
      end

      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign byte_tab[gi] = src_data[gi * 8 +: 8];
      end

      for (gi = 0; gi < 16; gi++) begin : g_zx
         localparam int GRP = gi / 8;
         localparam int BIT = 7 - (gi % 8);
         logic [7:0] attr;
         logic       dot;
         logic       swap;
         assign attr       = src_data[16 + GRP * 8 +: 8];
         assign dot        = src_data[GRP * 8 + BIT];
         assign swap       = attr[7] & flash_on;
         assign zx_tab[gi] = {vif.palsel, attr[6], (dot ^ swap) ? attr[2:0] : attr[5:3]};
      end
   endgenerate

   always_comb begin
      pix_sel = 8'h00;
      case (src_mode)
         MODE_4BPP: pix_sel = {vif.palsel, nib_tab[src_idx[2:0]]};
         MODE_8BPP: pix_sel = byte_tab[src_idx[1:0]];
         MODE_ZX:   pix_sel = zx_tab[src_idx];
         default:   pix_sel = 8'h00;
      endcase
   end

   always_comb begin
      hold_data_next = hold_data_reg;
      hold_full_next = hold_full_reg;
      sh_data_next   = sh_data_reg;
      sh_mode_next   = sh_mode_reg;
      sh_cnt_next    = sh_cnt_reg;
      pix_index_next = pix_index_reg;
      pix_valid_next = pix_valid_reg;
      underrun_next  = underrun_reg;
      overrun_next   = overrun_reg;

      if (vif.line_start) begin
         hold_full_next = 1'b0;
         sh_cnt_next    = 5'd0;
         pix_index_next = 8'h00;
         pix_valid_next = 1'b0;
         underrun_next  = 1'b0;
         overrun_next   = 1'b0;
      end else begin
         if (vif.pix_stb) begin
            if (!sh_empty) begin
               pix_index_next = pix_sel;
               pix_valid_next = 1'b1;
               sh_cnt_next    = sh_cnt_reg - 5'd1;
            end else if (load) begin
               sh_data_next   = hold_data_reg;
               sh_mode_next   = vif.mode;
               sh_cnt_next    = pix_per_word(vif.mode) - 5'd1;
               hold_full_next = 1'b0;
               pix_index_next = pix_sel;
               pix_valid_next = 1'b1;
            end else if (hold_full_reg) begin
               // Reserved mode: the word stays parked until a real mode is selected.
               pix_index_next = 8'h00;
               pix_valid_next = 1'b0;
            end else begin
               pix_index_next = 8'h00;
               pix_valid_next = 1'b0;
               underrun_next  = 1'b1;
            end
         end

         if (vif.fetch_stb) begin
            hold_data_next = vif.fetch_data;
            hold_full_next = 1'b1;
            if (hold_full_reg && !load) begin
               overrun_next = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_data_reg <= 32'h0;
         hold_full_reg <= 1'b0;
         sh_data_reg   <= 32'h0;
         sh_mode_reg   <= 2'd0;
         sh_cnt_reg    <= 5'd0;
         pix_index_reg <= 8'h00;
         pix_valid_reg <= 1'b0;
         underrun_reg  <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         hold_data_reg <= hold_data_next;
         hold_full_reg <= hold_full_next;
         sh_data_reg   <= sh_data_next;
         sh_mode_reg   <= sh_mode_next;
         sh_cnt_reg    <= sh_cnt_next;
         pix_index_reg <= pix_index_next;
         pix_valid_reg <= pix_valid_next;
         underrun_reg  <= underrun_next;
         overrun_reg   <= overrun_next;
      end
   end

   assign vif.pix_index = pix_index_reg;
   assign vif.pix_valid = pix_valid_reg;
   assign vif.underrun  = underrun_reg;
   assign vif.overrun   = overrun_reg;

endmodule

// File: tb/tb_video_pix_shift.sv
// Table-driven bench for video_pix_shift with a scoreboard queue of expected pixels,
// plus hand-written sequences for mid-line reset and the ZX flash option.
module tb_video_pix_shift;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   video_pix_shift_if vif ();

   video_pix_shift dut (
      .clk (clk),
      .rst (rst),
      .vif (vif)
   );

   typedef struct {
      logic        fetch;
      logic [31:0] data;
      logic [1:0]  mode;
      logic [3:0]  pal;
      logic        pix;
      logic        ls;
      logic [7:0]  e_idx;
      logic        e_val;
      logic        e_und;
      logic        e_ovr;
   } row_t;

   typedef struct packed {
      logic [7:0] idx;
      logic       val;
   } exp_t;

   row_t tbl[$];
   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

`ifdef VIDEO_SHIFT_FLASH_EN
   localparam logic [7:0] FL1_P0 = 8'h07;
   localparam logic [7:0] FL1_P1 = 8'h00;
`else
   localparam logic [7:0] FL1_P0 = 8'h00;
   localparam logic [7:0] FL1_P1 = 8'h07;
`endif

   function automatic row_t r(input logic fetch, input logic [31:0] data, input logic [1:0] mode,
                              input logic [3:0] pal, input logic pix, input logic ls,
                              input logic [7:0] e_idx, input logic e_val, input logic e_und,
                              input logic e_ovr);
      row_t t;
      t.fetch = fetch; t.data = data; t.mode = mode; t.pal = pal; t.pix = pix; t.ls = ls;
      t.e_idx = e_idx; t.e_val = e_val; t.e_und = e_und; t.e_ovr = e_ovr;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fetch, input logic [31:0] data, input logic [1:0] mode,
                        input logic [3:0] pal, input logic pix, input logic ls, input logic fl);
      vif.fetch_stb  = fetch;
      vif.fetch_data = data;
      vif.mode       = mode;
      vif.palsel     = pal;
      vif.pix_stb    = pix;
      vif.line_start = ls;
      vif.flash_ph   = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] a_exp [8];
      logic [7:0] b_exp [8];
      logic [7:0] c_exp [16];
      exp_t       last;
      exp_t       e;
      exp_t       got;

      a_exp = '{8'hA1, 8'hA0, 8'hA3, 8'hA2, 8'hA5, 8'hA4, 8'hA7, 8'hA6};
      b_exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
      c_exp = '{8'h00, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h00,
                8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h08, 8'h08, 8'h08, 8'h08};

      // 4bpp word, eight pixels, then an underrun
      tbl.push_back(r(1, 32'h76543210, 2'd0, 4'hA, 0, 0, 8'h00, 0, 0, 0));
      for (int k = 0; k < 8; k++) tbl.push_back(r(0, 32'h0, 2'd0, 4'hA, 1, 0, a_exp[k], 1, 0, 0));
      tbl.push_back(r(0, 32'h0, 2'd0, 4'hA, 1, 0, 8'h00, 0, 1, 0));
      tbl.push_back(r(0, 32'h0, 2'd0, 4'hA, 0, 1, 8'h00, 0, 0, 0));
      // 8bpp back-to-back, second fetch on the load cycle
      tbl.push_back(r(1, 32'hDDCCBBAA, 2'd1, 4'h0, 0, 0, 8'h00, 0, 0, 0));
      tbl.push_back(r(1, 32'h44332211, 2'd1, 4'h0, 1, 0, b_exp[0], 1, 0, 0));
      for (int k = 1; k < 8; k++) tbl.push_back(r(0, 32'h0, 2'd1, 4'h0, 1, 0, b_exp[k], 1, 0, 0));
      tbl.push_back(r(0, 32'h0, 2'd1, 4'h0, 0, 1, 8'h00, 0, 0, 0));
      // ZX bitmap + attribute
      tbl.push_back(r(1, 32'h4738F081, 2'd2, 4'h0, 0, 0, 8'h00, 0, 0, 0));
      for (int k = 0; k < 16; k++) tbl.push_back(r(0, 32'h0, 2'd2, 4'h0, 1, 0, c_exp[k], 1, 0, 0));
      tbl.push_back(r(0, 32'h0, 2'd2, 4'h0, 0, 1, 8'h00, 0, 0, 0));
      // overrun: second fetch overwrites the unused word
      tbl.push_back(r(1, 32'h00000001, 2'd1, 4'h0, 0, 0, 8'h00, 0, 0, 0));
      tbl.push_back(r(1, 32'h00000002, 2'd1, 4'h0, 0, 0, 8'h00, 0, 0, 1));
      tbl.push_back(r(0, 32'h0, 2'd1, 4'h0, 1, 0, 8'h02, 1, 0, 1));
      tbl.push_back(r(0, 32'h0, 2'd1, 4'h0, 0, 1, 8'h00, 0, 0, 0));
      // line_start mid-word drops a concurrent fetch and pixel
      tbl.push_back(r(1, 32'h76543210, 2'd0, 4'hA, 0, 0, 8'h00, 0, 0, 0));
      for (int k = 0; k < 3; k++) tbl.push_back(r(0, 32'h0, 2'd0, 4'hA, 1, 0, a_exp[k], 1, 0, 0));
      tbl.push_back(r(1, 32'hFFFFFFFF, 2'd0, 4'hA, 1, 1, 8'h00, 0, 0, 0));
      tbl.push_back(r(0, 32'h0, 2'd0, 4'hA, 1, 0, 8'h00, 0, 1, 0));
      tbl.push_back(r(0, 32'h0, 2'd0, 4'hA, 0, 1, 8'h00, 0, 0, 0));
      // reserved mode parks the word; later mode changes do not affect the word in flight
      tbl.push_back(r(1, 32'hA5B6C7D8, 2'd3, 4'h0, 0, 0, 8'h00, 0, 0, 0));
      tbl.push_back(r(0, 32'h0, 2'd3, 4'h0, 1, 0, 8'h00, 0, 0, 0));
      tbl.push_back(r(0, 32'h0, 2'd1, 4'h0, 1, 0, 8'hD8, 1, 0, 0));
      tbl.push_back(r(0, 32'h0, 2'd0, 4'h0, 1, 0, 8'hC7, 1, 0, 0));
      tbl.push_back(r(0, 32'h0, 2'd2, 4'h0, 1, 0, 8'hB6, 1, 0, 0));
      tbl.push_back(r(0, 32'h0, 2'd0, 4'h0, 1, 0, 8'hA5, 1, 0, 0));
      tbl.push_back(r(0, 32'h0, 2'd0, 4'h0, 1, 0, 8'h00, 0, 1, 0));
      tbl.push_back(r(0, 32'h0, 2'd0, 4'h0, 0, 1, 8'h00, 0, 0, 0));

      drive(0, 32'h0, 2'd0, 4'h0, 0, 0, 0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_pix_index", 32'(vif.pix_index), 32'h0);
      chk("reset_pix_valid", 32'(vif.pix_valid), 32'h0);
      chk("reset_underrun", 32'(vif.underrun), 32'h0);
      chk("reset_overrun", 32'(vif.overrun), 32'h0);
      $display("reset: idx=%h valid=%b und=%b ovr=%b", vif.pix_index, vif.pix_valid,
               vif.underrun, vif.overrun);

      last = '0;
      foreach (tbl[i]) begin
         drive(tbl[i].fetch, tbl[i].data, tbl[i].mode, tbl[i].pal, tbl[i].pix, tbl[i].ls, 1'b0);
         if (tbl[i].pix || tbl[i].ls) begin
            e.idx = tbl[i].e_idx;
            e.val = tbl[i].e_val;
         end else begin
            e = last;
         end
         sb.push_back(e);
         last = e;
         tick();
         got = sb.pop_front();
         chk($sformatf("row%0d_idx", i), 32'(vif.pix_index), 32'(got.idx));
         chk($sformatf("row%0d_valid", i), 32'(vif.pix_valid), 32'(got.val));
         chk($sformatf("row%0d_underrun", i), 32'(vif.underrun), 32'(tbl[i].e_und));
         chk($sformatf("row%0d_overrun", i), 32'(vif.overrun), 32'(tbl[i].e_ovr));
         $display("row %0d: fetch=%b pix=%b ls=%b mode=%0d -> idx=%h valid=%b und=%b ovr=%b",
                  i, tbl[i].fetch, tbl[i].pix, tbl[i].ls, tbl[i].mode, vif.pix_index,
                  vif.pix_valid, vif.underrun, vif.overrun);
      end

      // reset in the middle of a word
      drive(1, 32'h11223344, 2'd1, 4'h0, 0, 0, 0);
      tick();
      drive(0, 32'h0, 2'd1, 4'h0, 1, 0, 0);
      tick();
      chk("midrst_pre_idx", 32'(vif.pix_index), 32'h44);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_idx", 32'(vif.pix_index), 32'h0);
      chk("midrst_valid", 32'(vif.pix_valid), 32'h0);
      chk("midrst_underrun", 32'(vif.underrun), 32'h0);
      tick();
      chk("midrst_after_valid", 32'(vif.pix_valid), 32'h0);
      chk("midrst_after_underrun", 32'(vif.underrun), 32'h1);
      $display("midrst: idx=%h valid=%b und=%b", vif.pix_index, vif.pix_valid, vif.underrun);

      // ZX flash, phase 0 then phase 1
      drive(0, 32'h0, 2'd2, 4'h0, 0, 1, 0);
      tick();
      drive(1, 32'h00B80080, 2'd2, 4'h0, 0, 0, 0);
      tick();
      drive(0, 32'h0, 2'd2, 4'h0, 1, 0, 0);
      tick();
      chk("flash0_p0", 32'(vif.pix_index), 32'h00);
      tick();
      chk("flash0_p1", 32'(vif.pix_index), 32'h07);
      $display("flash_ph=0: last idx=%h", vif.pix_index);
      drive(0, 32'h0, 2'd2, 4'h0, 0, 1, 1);
      tick();
      drive(1, 32'h00B80080, 2'd2, 4'h0, 0, 0, 1);
      tick();
      drive(0, 32'h0, 2'd2, 4'h0, 1, 0, 1);
      tick();
      chk("flash1_p0", 32'(vif.pix_index), 32'(FL1_P0));
      tick();
      chk("flash1_p1", 32'(vif.pix_index), 32'(FL1_P1));
      $display("flash_ph=1: last idx=%h", vif.pix_index);

      drive(0, 32'h0, 2'd0, 4'h0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
